// File: rtl/axi2apb_pkg.sv
// ---------------------------------------------------------------
// axi2apb_pkg : shared state encoding and flat-vector slice widths
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package axi2apb_pkg;

  localparam int PLEN_W = 8;
  localparam int PROT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/axi2apb_apb_sn_if.sv
// ---------------------------------------------------------------
// axi2apb_apb_sn_if : request handshake plus APB master bus
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

interface axi2apb_apb_sn_if
  import axi2apb_pkg::*;
#(
  parameter int NUM_PSLAVE = 8,
  parameter int WIDTH_PAD  = 32,
  parameter int WIDTH_PDA  = 32
);
  localparam int WIDTH_PDS = WIDTH_PDA / 8;

  logic                            REQ;
  logic                            ACK;
  logic [WIDTH_PAD-1:0]            ADDR;
  logic                            WR;
  logic [WIDTH_PDA-1:0]            DATAW;
  logic [WIDTH_PDS-1:0]            BE;
  logic [PROT_W-1:0]               PROT;
  logic [WIDTH_PDA-1:0]            DATAR;
  logic                            ERROR;

  logic [WIDTH_PAD-1:0]            PADDR;
  logic                            PWRITE;
  logic [WIDTH_PDA-1:0]            PWDATA;
  logic [WIDTH_PDS-1:0]            PSTRB;
  logic [PROT_W-1:0]               PPROT;
  logic [NUM_PSLAVE-1:0]           PSEL;
  logic                            PENABLE;
  logic [NUM_PSLAVE*WIDTH_PDA-1:0] PRDATA;
  logic [NUM_PSLAVE-1:0]           PREADY;
  logic [NUM_PSLAVE-1:0]           PSLVERR;

  // master: the bridge itself; slave: requester plus the APB slaves
  modport master (
    input  REQ, ADDR, WR, DATAW, BE, PROT, PRDATA, PREADY, PSLVERR,
    output ACK, DATAR, ERROR, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSEL, PENABLE
  );

  modport slave (
    output REQ, ADDR, WR, DATAW, BE, PROT, PRDATA, PREADY, PSLVERR,
    input  ACK, DATAR, ERROR, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSEL, PENABLE
  );

endinterface

`default_nettype wire

// File: rtl/axi2apb_apb_dec.sv
// ---------------------------------------------------------------
// axi2apb_apb_dec : base/length address decode, lowest index wins
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module axi2apb_apb_dec
  import axi2apb_pkg::*;
#(
  parameter int                               NUM_PSLAVE   = 8,
  parameter int                               WIDTH_PAD    = 32,
  parameter logic [NUM_PSLAVE*WIDTH_PAD-1:0]  ADDR_PBASE   = '0,
  parameter logic [NUM_PSLAVE*PLEN_W-1:0]     ADDR_PLENGTH = {NUM_PSLAVE{8'd12}}
) (
  input  logic [WIDTH_PAD-1:0]  addr,
  output logic [NUM_PSLAVE-1:0] hit,
  output logic                  miss
);

  logic [NUM_PSLAVE-1:0] raw_hit;

  for (genvar i = 0; i < NUM_PSLAVE; i++) begin : g_slave
    localparam int PLEN = int'(ADDR_PLENGTH[i*PLEN_W +: PLEN_W]);
    localparam logic [WIDTH_PAD-1:0] BASE = ADDR_PBASE[i*WIDTH_PAD +: WIDTH_PAD];
    // Only the bits above the window size take part in the compare
    localparam logic [WIDTH_PAD-1:0] MASK =
      (PLEN >= WIDTH_PAD) ? '0 : ({WIDTH_PAD{1'b1}} << PLEN);
    assign raw_hit[i] = (((addr ^ BASE) & MASK) == '0);
  end

  always_comb begin
    logic found;
    found = 1'b0;
    hit   = '0;
    for (int i = 0; i < NUM_PSLAVE; i++) begin
      if (raw_hit[i] && !found) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign miss = ~|raw_hit;

endmodule

`default_nettype wire

// File: rtl/axi2apb_apb_sn.sv
// ---------------------------------------------------------------
// axi2apb_apb_sn : 4-phase request to multi-slave APB bridge
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module axi2apb_apb_sn
  import axi2apb_pkg::*;
#(
  parameter int                               NUM_PSLAVE   = 8,
  parameter int                               WIDTH_PAD    = 32,
  parameter int                               WIDTH_PDA    = 32,
  parameter logic [NUM_PSLAVE*WIDTH_PAD-1:0]  ADDR_PBASE   = {
    32'h0000_7000, 32'h0000_6000, 32'h0000_5000, 32'h0000_4000,
    32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_PSLAVE*PLEN_W-1:0]     ADDR_PLENGTH = {NUM_PSLAVE{8'd12}},
  parameter int                               TIMEOUT      = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  axi2apb_apb_sn_if.master  bus
);

  localparam int WIDTH_PDS = WIDTH_PDA / 8;
  localparam int TW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT);

  state_e                 state_q,   state_d;
  logic [WIDTH_PAD-1:0]   paddr_q,   paddr_d;
  logic                   pwrite_q,  pwrite_d;
  logic [WIDTH_PDA-1:0]   pwdata_q,  pwdata_d;
  logic [WIDTH_PDS-1:0]   pstrb_q,   pstrb_d;
  logic [PROT_W-1:0]      pprot_q,   pprot_d;
  logic [NUM_PSLAVE-1:0]  psel_q,    psel_d;
  logic                   penable_q, penable_d;
  logic                   ack_q,     ack_d;
  logic [WIDTH_PDA-1:0]   datar_q,   datar_d;
  logic                   error_q,   error_d;
  logic [TW-1:0]          tcnt_q,    tcnt_d;

  logic [NUM_PSLAVE-1:0]  dec_hit;
  logic                   dec_miss;
  logic                   sel_ready;
  logic                   sel_err;
  logic [WIDTH_PDA-1:0]   sel_rdata;

  axi2apb_apb_dec #(
    .NUM_PSLAVE   (NUM_PSLAVE),
    .WIDTH_PAD    (WIDTH_PAD),
    .ADDR_PBASE   (ADDR_PBASE),
    .ADDR_PLENGTH (ADDR_PLENGTH)
  ) u_dec (
    .addr (bus.ADDR),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  // psel_q is one-hot, so OR-combining the selected slices is a mux
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_PSLAVE; i++) begin
      if (psel_q[i]) begin
        sel_ready = sel_ready | bus.PREADY[i];
        sel_err   = sel_err   | bus.PSLVERR[i];
        sel_rdata = sel_rdata | bus.PRDATA[i*WIDTH_PDA +: WIDTH_PDA];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    ack_d     = ack_q;
    datar_d   = datar_q;
    error_d   = error_q;
    tcnt_d    = tcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.REQ) begin
          paddr_d  = bus.ADDR;
          pwrite_d = bus.WR;
          pwdata_d = bus.DATAW;
          pstrb_d  = bus.WR ? bus.BE : '0;
          pprot_d  = bus.PROT;
          tcnt_d   = '0;
          if (dec_miss) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
            error_d = 1'b1;
            datar_d = '0;
          end else begin
            state_d = ST_SETUP;
            psel_d  = dec_hit;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          state_d   = ST_DONE;
          psel_d    = '0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
          datar_d   = pwrite_q ? '0 : sel_rdata;
          error_d   = sel_err;
        end else if ((TIMEOUT != 0) && (tcnt_q == TLIMIT)) begin
          state_d   = ST_DONE;
          psel_d    = '0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
          datar_d   = '0;
          error_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (!bus.REQ) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      ack_q     <= 1'b0;
      datar_q   <= '0;
      error_q   <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ack_q     <= ack_d;
      datar_q   <= datar_d;
      error_q   <= error_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PSTRB   = pstrb_q;
  assign bus.PPROT   = pprot_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.ACK     = ack_q;
  assign bus.DATAR   = datar_q;
  assign bus.ERROR   = error_q;

endmodule

`default_nettype wire

// File: tb/tb_axi2apb_apb_sn.sv
// ---------------------------------------------------------------
// tb_axi2apb_apb_sn : directed scoreboard bench for the APB bridge
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_axi2apb_apb_sn;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  axi2apb_apb_sn_if #(.NUM_PSLAVE(8), .WIDTH_PAD(32), .WIDTH_PDA(32)) bus ();

  axi2apb_apb_sn #(
    .NUM_PSLAVE (8),
    .WIDTH_PAD  (32),
    .WIDTH_PDA  (32),
    .TIMEOUT    (4)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // APB slave models: selected slave becomes ready after wait_n access cycles,
  // unselected slaves always report ready so a bad mux shows up
  int          wait_n  = 0;
  int          acc_cnt = 0;
  logic [7:0]  slverr_v = 8'h00;
  logic [255:0] prdata_v;

  always @(posedge PCLK) begin
    if (bus.PENABLE && (|bus.PSEL)) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  assign bus.PREADY  = (acc_cnt >= wait_n) ? 8'hFF : ~bus.PSEL;
  assign bus.PSLVERR = slverr_v;
  assign bus.PRDATA  = prdata_v;

  int          psel_cyc = 0, pen_cyc = 0, onehot_bad = 0, unstable = 0;
  logic [7:0]  mon_sel;
  logic [3:0]  mon_strb;
  logic [31:0] mon_addr, mon_wdata, setup_addr;
  logic        mon_write;
  logic [2:0]  mon_prot;

  always @(negedge PCLK) begin
    if (|bus.PSEL) psel_cyc <= psel_cyc + 1;
    if ((|bus.PSEL) && !$onehot(bus.PSEL)) onehot_bad <= onehot_bad + 1;
    if ((|bus.PSEL) && !bus.PENABLE) setup_addr <= bus.PADDR;
    if (bus.PENABLE) begin
      pen_cyc   <= pen_cyc + 1;
      mon_sel   <= bus.PSEL;
      mon_strb  <= bus.PSTRB;
      mon_addr  <= bus.PADDR;
      mon_wdata <= bus.PWDATA;
      mon_write <= bus.PWRITE;
      mon_prot  <= bus.PPROT;
      if (bus.PADDR !== setup_addr) unstable <= unstable + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be, input logic [2:0] prot,
                      input int wt, input logic [31:0] exp_d, input logic exp_e,
                      input int exp_lat, input int exp_pen, input logic [7:0] exp_sel);
    int   p0, e0, lat;
    exp_t e;
    sb.push_back('{data: exp_d, err: exp_e});
    wait_n    = wt;
    p0        = psel_cyc;
    e0        = pen_cyc;
    bus.ADDR  = addr;
    bus.WR    = wr;
    bus.DATAW = wd;
    bus.BE    = be;
    bus.PROT  = prot;
    bus.REQ   = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.ACK && lat < 60);
    chk({tag, "/ack_latency"}, lat, exp_lat);
    e = sb.pop_front();
    chk({tag, "/datar"}, bus.DATAR, e.data);
    chk({tag, "/error"}, bus.ERROR, e.err);
    chk({tag, "/psel_cycles"}, psel_cyc - p0, (exp_sel == 8'h00) ? 0 : exp_pen + 1);
    chk({tag, "/penable_cycles"}, pen_cyc - e0, exp_pen);
    if (exp_sel != 8'h00) begin
      chk({tag, "/psel"}, mon_sel, exp_sel);
      chk({tag, "/pstrb"}, mon_strb, wr ? be : 4'h0);
      chk({tag, "/paddr"}, mon_addr, addr);
      chk({tag, "/pwrite"}, mon_write, wr);
      chk({tag, "/pprot"}, mon_prot, prot);
      if (wr) chk({tag, "/pwdata"}, mon_wdata, wd);
    end
    tick();
    tick();
    chk({tag, "/ack_hold"}, bus.ACK, 1'b1);
    chk({tag, "/datar_hold"}, bus.DATAR, exp_d);
    chk({tag, "/psel_done"}, bus.PSEL, 8'h00);
    bus.REQ = 1'b0;
    tick();
    chk({tag, "/ack_drop"}, bus.ACK, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) prdata_v[i*32 +: 32] = 32'h5A00_0000 | i;
    prdata_v[3*32 +: 32] = 32'hCAFE_F00D;
    bus.REQ   = 1'b0;
    bus.ADDR  = '0;
    bus.WR    = 1'b0;
    bus.DATAW = '0;
    bus.BE    = '0;
    bus.PROT  = '0;

    tick();
    tick();
    chk("reset/ack",     bus.ACK,     1'b0);
    chk("reset/psel",    bus.PSEL,    8'h00);
    chk("reset/penable", bus.PENABLE, 1'b0);
    chk("reset/datar",   bus.DATAR,   32'h0);
    chk("reset/error",   bus.ERROR,   1'b0);
    chk("reset/paddr",   bus.PADDR,   32'h0);
    chk("reset/pstrb",   bus.PSTRB,   4'h0);
    PRESET = 1'b0;
    tick();
    tick();
    chk("idle/psel", bus.PSEL, 8'h00);

    xfer("rd3",       32'h0000_3010, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010, 0,
         32'hCAFE_F00D, 1'b0, 3, 1, 8'h08);
    xfer("wr5",       32'h0000_5004, 1'b1, 32'h1234_5678, 4'h3, 3'b001, 4,
         32'h0, 1'b0, 7, 5, 8'h20);
    xfer("miss9000",  32'h0000_9000, 1'b0, 32'h0, 4'hF, 3'b000, 0,
         32'h0, 1'b1, 1, 0, 8'h00);
    xfer("miss8000",  32'h0000_8000, 1'b1, 32'hAAAA_5555, 4'hF, 3'b000, 0,
         32'h0, 1'b1, 1, 0, 8'h00);
    xfer("miss_hi",   32'h0001_3000, 1'b0, 32'h0, 4'h0, 3'b000, 0,
         32'h0, 1'b1, 1, 0, 8'h00);
    xfer("timeout",   32'h0000_1008, 1'b0, 32'h0, 4'hF, 3'b100, 100,
         32'h0, 1'b1, 7, 5, 8'h02);
    xfer("wr7",       32'h0000_7FFC, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b111, 1,
         32'h0, 1'b0, 4, 2, 8'h80);
    slverr_v = 8'h04;
    xfer("slverr2",   32'h0000_2000, 1'b0, 32'h0, 4'h0, 3'b000, 0,
         32'h5A00_0002, 1'b1, 3, 1, 8'h04);
    slverr_v = 8'h00;
    xfer("after_err", 32'h0000_6FFC, 1'b0, 32'h0, 4'h0, 3'b011, 2,
         32'h5A00_0006, 1'b0, 5, 3, 8'h40);

    // Reset pulse in the middle of a stalled access
    wait_n    = 100;
    bus.ADDR  = 32'h0000_4000;
    bus.WR    = 1'b1;
    bus.DATAW = 32'h0BAD_0BAD;
    bus.BE    = 4'hC;
    bus.PROT  = 3'b101;
    bus.REQ   = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_mid/penable_before", bus.PENABLE, 1'b1);
    #1 PRESET = 1'b1;
    #1;
    chk("rst_mid/psel",    bus.PSEL,    8'h00);
    chk("rst_mid/penable", bus.PENABLE, 1'b0);
    chk("rst_mid/ack",     bus.ACK,     1'b0);
    chk("rst_mid/datar",   bus.DATAR,   32'h0);
    chk("rst_mid/error",   bus.ERROR,   1'b0);
    chk("rst_mid/paddr",   bus.PADDR,   32'h0);
    chk("rst_mid/pwdata",  bus.PWDATA,  32'h0);
    chk("rst_mid/pstrb",   bus.PSTRB,   4'h0);
    chk("rst_mid/pprot",   bus.PPROT,   3'h0);
    chk("rst_mid/pwrite",  bus.PWRITE,  1'b0);
    bus.REQ = 1'b0;
    tick();
    PRESET = 1'b0;
    tick();
    tick();
    chk("rst_after/ack",  bus.ACK,  1'b0);
    chk("rst_after/psel", bus.PSEL, 8'h00);
    xfer("rd0_after_rst", 32'h0000_0124, 1'b0, 32'h0, 4'h0, 3'b000, 0,
         32'h5A00_0000, 1'b0, 3, 1, 8'h01);

    chk("psel_onehot",   onehot_bad, 0);
    chk("paddr_stable",  unstable,   0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi2apb_apb_sn.md
AXI2APB_APB_SN -- requirements
Module: axi2apb_apb_sn

Interface
REQ-001 SHALL have parameter NUM_PSLAVE, default 8: number of APB slaves, 1..16.
REQ-002 SHALL have parameter WIDTH_PAD, default 32: address width.
REQ-003 SHALL have parameter WIDTH_PDA, default 32: data width, 32 or 64; WIDTH_PDS = WIDTH_PDA/8.
REQ-004 SHALL have parameter ADDR_PBASE, default slave i at i*0x1000: flat NUM_PSLAVE*WIDTH_PAD vector; slice i is slave i's base.
REQ-005 SHALL have parameter ADDR_PLENGTH, default 12 per slave: flat NUM_PSLAVE*8 vector; slice i is slave i's log2 window size.
REQ-006 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles before forced termination; 0 disables the timeout.
REQ-007 Ports: PCLK  in  1  clock. One clock; all logic on the rising edge.
REQ-008 Ports: PRESET  in  1  reset, asynchronous, active-high.
REQ-009 Ports: REQ in 1 request level; ACK out 1 done level (4-phase handshake).
REQ-010 Ports: ADDR in WIDTH_PAD; WR in 1; DATAW in WIDTH_PDA; BE in WIDTH_PDS; PROT in 3.
REQ-011 Ports: DATAR out WIDTH_PDA read data; ERROR out 1 transfer error.
REQ-012 Ports: PADDR out WIDTH_PAD; PWRITE out 1; PWDATA out WIDTH_PDA; PSTRB out WIDTH_PDS; PPROT out 3.
REQ-013 Ports: PSEL out NUM_PSLAVE; PENABLE out 1.
REQ-014 Ports: PRDATA in NUM_PSLAVE*WIDTH_PDA (flat, slice i = slave i); PREADY in NUM_PSLAVE; PSLVERR in NUM_PSLAVE.

Function
REQ-015 SHALL implement states IDLE, SETUP, ACCESS, DONE.
REQ-016 IDLE: REQ=1 at an edge SHALL register ADDR/WR/DATAW/BE/PROT and decode them; on a hit, go to SETUP; on a miss, go to DONE with ERROR=1 and DATAR=0, with no PSEL asserted.
REQ-017 Decode: slave i SHALL hit when ADDR[WIDTH_PAD-1:PLENGTH_i] equals the same bits of BASE_i; with multiple hits, the lowest index SHALL win.
REQ-018 SETUP: exactly one PSEL bit SHALL be high and PENABLE=0; the state SHALL advance unconditionally to ACCESS after one cycle.
REQ-019 ACCESS: PENABLE=1; the block SHALL stay in ACCESS while the selected PREADY=0.
REQ-020 ACCESS with selected PREADY=1 SHALL capture the selected PRDATA slice (reads only; writes give DATAR=0) and PSLVERR into ERROR, then go to DONE.
REQ-021 A timeout counter SHALL clear on SETUP entry and increment each ACCESS cycle; at count==TIMEOUT with PREADY=0 it SHALL force DONE with ERROR=1 and DATAR=0.
REQ-022 DONE: PSEL=0, PENABLE=0, ACK=1; DATAR/ERROR SHALL hold stable; when REQ=0, go to IDLE and drop ACK next cycle.
REQ-023 Latency: REQ sampled at edge k gives SETUP in cycle k+1, ACCESS in k+2; PREADY sampled at edge m gives ACK=1 at m+1.
REQ-024 A new REQ SHALL NOT start until the prior ACK has returned to 0 (REQ must fall first).
REQ-025 PSTRB SHALL equal BE on writes and SHALL be all zero on reads.
REQ-026 PADDR, PWRITE, PWDATA, PSTRB and PPROT SHALL come from registers and hold stable from SETUP through ACCESS.

Reset
REQ-027 PRESET=1 SHALL force, asynchronously: state IDLE; PSEL=0, PENABLE=0, ACK=0, ERROR=0, DATAR=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, PWRITE=0; timeout count=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no ACK; after release the block SHALL wait in IDLE for REQ.

Structure
REQ-029 State encoding and the flat-vector slice width constants SHALL live in package axi2apb_pkg.
REQ-030 Address decode SHALL be sub-module axi2apb_apb_dec, which outputs a one-hot hit vector and a miss flag.

Verification
REQ-031 Read slave 3 (ADDR 0x3010, PREADY=1 immediately, PRDATA_3=0xCAFEF00D): PSEL[3] for 2 cycles, then ACK=1, DATAR=0xCAFEF00D, ERROR=0.
REQ-032 Write 0x5004 with BE=0x3 and slave 5 PREADY delayed 4 cycles: PENABLE high 5 cycles, PSTRB=0x3, ACK after the PREADY edge.
REQ-033 ADDR 0x9000 with NUM_PSLAVE=8: no PSEL, ACK 1 cycle after REQ, ERROR=1.
REQ-034 TIMEOUT=4 and PREADY stuck at 0: PENABLE high 5 cycles then dropped; ACK=1, ERROR=1.
REQ-035 PSLVERR_2=1 with PREADY: ERROR=1; the next good transfer returns ERROR=0.
REQ-036 PRESET pulsed during ACCESS: all outputs zero immediately; the next REQ completes normally.
